multiphase_mod_clkgen: RTL

//  Parametrised successor of the single-channel modulation clock generator.
//  It divides CLK_IN into one programmable modulation period and drives NCH

---
 rtl/mbimager_clkgen_pkg.sv | 40 ++++
 rtl/mod_phase_chan.sv | 59 +++++
 rtl/multiphase_mod_clkgen.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mbimager_clkgen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mbimager_clkgen_pkg
//  Description : Shared types and helpers for the multiphase modulation clock
//                generator: FSM state encoding, minimum period exponent and
//                the per-channel high-time clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
package mbimager_clkgen_pkg;

    // Smallest supported period is 2**P_MIN_LOG2 clocks, so the divider
    // exponent is clamped to CNT_W - P_MIN_LOG2.
    localparam int P_MIN_LOG2 = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // High time in clocks for one channel:
    //   h = min((duty >> d) + 1, P/2 - dead), never below 1.
    // Capping at P/2 - dead keeps MOD and MODN apart by at least 'dead'
    // clocks; a dead time that eats the whole half period leaves a
    // one-clock pulse rather than silencing the channel.
    function automatic int clamp_high(input int duty, input int d,
                                      input int dead, input int cnt_w);
        int half;
        int h;
        half = 1 << (cnt_w - 1 - d);
        h    = (duty >> d) + 1;
        if (h > half - dead)
            h = half - dead;
        if (h < 1)
            h = 1;
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_phase_chan.sv
`default_nettype none
// ============================================================================
//  Module      : mod_phase_chan
//  Description : One complementary MOD/MODN output pair. Compares the shared
//                period counter, rotated by this channel's phase, against the
//                channel's high time. MODN is the same pulse shifted by half
//                a period. Both outputs are flops.
//  Ports       : CLK_IN  clock (rising edge)
//                RST     asynchronous active-high reset
//                en      counter is live this cycle; outputs forced low if 0
//                cnt     shared period counter
//                mask    P-1 for the current period
//                half    P/2 for the current period
//                ph      shadowed phase, already scaled to the period
//                h       shadowed high time in clocks (1 .. P/2)
//                mod     registered modulation output
//                modn    registered complementary output
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_phase_chan #(
    parameter int CNT_W = 5
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             en,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] mask,
    input  logic [CNT_W-1:0] half,
    input  logic [CNT_W-1:0] ph,
    input  logic [CNT_W-1:0] h,
    output logic             mod,
    output logic             modn
);

    logic [CNT_W-1:0] w_rel;
    logic [CNT_W-1:0] w_reln;
    logic             r_mod;
    logic             r_modn;

    // Position within the period relative to this channel's rising edge;
    // the mask makes the subtraction wrap modulo P rather than 2**CNT_W.
    assign w_rel  = (cnt - ph) & mask;
    assign w_reln = (cnt - ph - half) & mask;

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            r_mod  <= 1'b0;
            r_modn <= 1'b0;
        end else begin
            r_mod  <= en && (w_rel  < h);
            r_modn <= en && (w_reln < h);
        end
    end

    assign mod  = r_mod;
    assign modn = r_modn;

endmodule
`default_nettype wire

// File: rtl/multiphase_mod_clkgen.sv
`default_nettype none
// ============================================================================
//  Module      : multiphase_mod_clkgen
//  Description : Divides CLK_IN into a programmable modulation period and
//                drives NCH complementary MOD/MODN pairs with individual
//                phase and duty, a 50% MODL reference, a period SYNC pulse
//                and a config-reload acknowledge. Configuration is shadowed
//                and only reloaded at the period wrap.
//  Ports       : CLK_IN        clock (rising edge)
//                RST           asynchronous active-high reset
//                DRAIN_B       run enable, low = idle with outputs low
//                DIV_SEL       period P = 2**(CNT_W-d), d = min(DIV_SEL, CNT_W-2)
//                PHASE_SEL     per-channel phase, chan i at [i*CNT_W +: CNT_W]
//                DUTY_SEL      per-channel high-time code, same packing
//                DEAD_SEL      shared dead time in clocks
//                CLK_OUT_MOD   per-channel modulation clock
//                CLK_OUT_MODN  per-channel complement, half a period later
//                CLK_OUT_MODL  reference square wave, 50% duty
//                SYNC_OUT      pulse on the first output cycle of each period
//                CFG_ACK       pulse after a shadow reload at wrap
//  Revision    : 1.0 - initial release
// ============================================================================
module multiphase_mod_clkgen
    import mbimager_clkgen_pkg::*;
#(
    parameter int CNT_W    = 5,
    parameter int NCH      = 2,
    parameter int DT_W     = 2,
    parameter int GRACEFUL = 0
) (
    input  logic                 CLK_IN,
    input  logic                 RST,
    input  logic                 DRAIN_B,
    input  logic [2:0]           DIV_SEL,
    input  logic [NCH*CNT_W-1:0] PHASE_SEL,
    input  logic [NCH*CNT_W-1:0] DUTY_SEL,
    input  logic [DT_W-1:0]      DEAD_SEL,
    output logic [NCH-1:0]       CLK_OUT_MOD,
    output logic [NCH-1:0]       CLK_OUT_MODN,
    output logic                 CLK_OUT_MODL,
    output logic                 SYNC_OUT,
    output logic                 CFG_ACK
);

    localparam logic [2:0]       c_d_max = 3'(CNT_W - P_MIN_LOG2);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;

    // Shadow configuration used by the running period
    logic [2:0]           r_d;
    logic [NCH*CNT_W-1:0] r_phase;
    logic [NCH*CNT_W-1:0] r_duty;
    logic [DT_W-1:0]      r_dead;

    logic                 r_modl;
    logic                 r_sync;
    logic                 r_ack;

    logic [2:0]           w_d_in;
    logic [CNT_W-1:0]     w_mask;
    logic [CNT_W-1:0]     w_half;
    logic                 w_wrap;
    logic                 w_active;
    logic                 w_load;

    assign w_d_in = (DIV_SEL > c_d_max) ? c_d_max : DIV_SEL;
    assign w_mask = {CNT_W{1'b1}} >> r_d;
    assign w_half = (w_mask >> 1) + c_one;
    assign w_wrap = (r_cnt == w_mask);

    // ------------------------------------------------------------------
    // FSM
    // w_active means "this edge advances the counter and produces an
    // output cycle". It is low in IDLE and on the abort edge of a
    // non-graceful stop, so cnt and every output drop on that same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_active    = 1'b0;
        case (r_state)
            IDLE: begin
                if (DRAIN_B)
                    w_state_nxt = RUN;
            end
            RUN: begin
                w_active = DRAIN_B || (GRACEFUL != 0);
                if (!DRAIN_B) begin
                    // A graceful stop requested on the last cycle of a
                    // period has nothing left to finish.
                    if ((GRACEFUL == 0) || w_wrap)
                        w_state_nxt = IDLE;
                    else
                        w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_active = 1'b1;
                if (DRAIN_B)
                    w_state_nxt = RUN;
                else if (w_wrap)
                    w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Shadow tracks the inputs while idle so the first period after start
    // already uses the current settings; while running it only moves at
    // the wrap so no pulse is cut short or stretched.
    assign w_load = (r_state == IDLE) || (w_active && w_wrap);

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            r_d     <= '0;
            r_phase <= '0;
            r_duty  <= '0;
            r_dead  <= '0;
        end else if (w_load) begin
            r_d     <= w_d_in;
            r_phase <= PHASE_SEL;
            r_duty  <= DUTY_SEL;
            r_dead  <= DEAD_SEL;
        end
    end

    // Counter and shared outputs; all outputs describe the counter value
    // seen on the edge that registers them.
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            r_cnt  <= '0;
            r_modl <= 1'b0;
            r_sync <= 1'b0;
            r_ack  <= 1'b0;
        end else begin
            r_cnt  <= w_active ? ((r_cnt + c_one) & w_mask) : '0;
            r_modl <= w_active && (r_cnt < w_half);
            r_sync <= w_active && (r_cnt == '0);
            r_ack  <= w_active && w_wrap;
        end
    end

    assign CLK_OUT_MODL = r_modl;
    assign SYNC_OUT     = r_sync;
    assign CFG_ACK      = r_ack;

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        logic [CNT_W-1:0] w_ph;
        logic [CNT_W-1:0] w_h;

        assign w_ph = r_phase[gi*CNT_W +: CNT_W] >> r_d;
        assign w_h  = CNT_W'(clamp_high(int'(r_duty[gi*CNT_W +: CNT_W]),
                                        int'(r_d), int'(r_dead), CNT_W));

        mod_phase_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .CLK_IN (CLK_IN),
            .RST    (RST),
            .en     (w_active),
            .cnt    (r_cnt),
            .mask   (w_mask),
            .half   (w_half),
            .ph     (w_ph),
            .h      (w_h),
            .mod    (CLK_OUT_MOD[gi]),
            .modn   (CLK_OUT_MODN[gi])
        );
    end

endmodule
`default_nettype wire
